// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one sum/carry cell plus one carry flop, LSB-first.
// Latency: done pulses WIDTH cycles after the start edge; one op in flight.
// Backpressure: start is ignored while busy (no queuing); DONE accepts start back-to-back.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, sub      request strobe and op select (0 = add, 1 = subtract)
//   a_in, b_in      parallel operands, sampled only on the accepted start edge
//   busy            high while bits are being processed
//   done            one-cycle pulse; s_out/c_out valid and held until next done/reset
//   s_out, c_out    result and final carry (for subtract: 1 = no borrow)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic             sum_bit;
  logic             carry_nxt;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] acc_nxt;

  // One-bit sum/carry cell working on the current LSBs.
  assign sum_bit   = a_reg[0] ^ b_reg[0] ^ carry;
  assign carry_nxt = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);

  // New sum bit enters at the MSB end so that after WIDTH shifts bit 0 lands at acc[0].
  assign acc_nxt = {sum_bit, acc[WIDTH-1:1]};

  assign load = start && (state != ST_RUN);
  assign last = (state == ST_RUN) && (cnt == LAST_BIT);

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (cnt == LAST_BIT) next_state = ST_DONE;
      ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s_out <= '0;
      c_out <= 1'b0;
    end else if (load) begin
      // Subtract as A + ~B + 1: the +1 rides in as the initial carry.
      a_reg <= a_in;
      b_reg <= sub ? ~b_in : b_in;
      carry <= sub;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      carry <= carry_nxt;
      cnt   <= cnt + CNT_W'(1);
      acc   <= acc_nxt;
      // Outputs only change on the final bit so partial sums never show.
      if (last) begin
        s_out <= acc_nxt;
        c_out <= carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): add/sub vectors, ignored start,
// back-to-back start, and mid-operation reset.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] s_out;
  logic         c_out;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .s_out (s_out),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive a start on the next edge (E0); returns #1 after E0 with start still as given.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Wait for done with a bounded number of edges; returns edges after E0 (0 = timeout).
  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_s, input logic exp_c);
    int lat;
    issue(a, b, s);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(20, lat);
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_s"}, 32'(s_out), 32'(exp_s));
    check({tag, "_c"}, 32'(c_out), 32'(exp_c));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int done_cnt;

    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s_out), 32'd0);
    check("rst_c", 32'(c_out), 32'd0);
    reset = 1'b0;

    // Plain add / subtract vectors.
    run_op("add00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("add5a", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("addff", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("sub10", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    run_op("sub01", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);

    // Start pulse during RUN is ignored.
    issue(8'h01, 8'h01, 1'b0);
    start    = 1'b0;
    busy_cnt = 32'(busy);
    done_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 3) begin
        a_in  = 8'h11;
        b_in  = 8'h22;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      busy_cnt += 32'(busy);
      if (done) begin
        done_cnt++;
        check("ign_s", 32'(s_out), 32'h02);
        check("ign_c", 32'(c_out), 32'd0);
      end
    end
    check("ign_busy_cycles", 32'(busy_cnt), 32'd8);
    check("ign_done_cnt", 32'(done_cnt), 32'd1);

    // start held through DONE launches a back-to-back op; later operand changes while busy are ignored.
    issue(8'h01, 8'h02, 1'b0);
    a_in = 8'h80;
    b_in = 8'h80;
    wait_done(20, lat);
    check("b2b_lat1", 32'(lat), 32'd8);
    check("b2b_s1", 32'(s_out), 32'h03);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(20, lat);
    check("b2b_lat2", 32'(lat), 32'd8);
    check("b2b_s2", 32'(s_out), 32'h00);
    check("b2b_c2", 32'(c_out), 32'd1);

    // Reset while processing bit 4 of 0xF0+0x0F.
    issue(8'hF0, 8'h0F, 1'b0);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_s", 32'(s_out), 32'd0);
    check("mrst_c", 32'(c_out), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("mrst_no_done", 32'(done_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
